spi_s: RTL and testbench
========================

Name: spi_s

Overview:
- SPI slave (target) endpoint, the far end of the team's SPI master: receives MOSI bytes and returns MISO bytes, MSB first, 8-bit frames.
- All four modes (cpol/cpha), matching the master's mode inputs.
- sclk, ss_n and mosi are asynchronous to clk. They are synchronised and oversampled in the clk domain. No logic is clocked by sclk.
- Sits between an off-chip or on-chip SPI master and a local byte-wide register/FIFO interface.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on sclk, ss_n and mosi (minimum 2).
- DW, 8, frame width in bits (tests use 8).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- cpol  input  1  sclk idle level; static while ss_n is low.
- cpha  input  1  0: sample on leading edge; 1: sample on trailing edge; static while ss_n is low.
- sclk  input  1  serial clock from master (async).
- ss_n  input  1  slave select, active low (async).
- mosi  input  1  serial data from master (async).
- din  input  DW  byte to return on miso; sampled at select and at each done.
- miso  output  1  serial data to master.
- miso_oe  output  1  1 while selected; drives an external tri-state buffer.
- dout  output  DW  last complete received byte; held until the next done.
- done  output  1  one-clk pulse: a full byte was received and dout is updated.
- ready  output  1  1 when ss_n (synchronised) is high, i.e. idle.
- abort  output  1  one-clk pulse: ss_n deasserted with 1..DW-1 bits of a frame received.

Behaviour:
- Reset values: miso=0, miso_oe=0, dout=0, done=0, ready=1, abort=0. Bit counter=0, shift registers=0, synchroniser flops reset to idle (ss_n=1, sclk=0, mosi=0).
- Synchronisation:
  - SYNC_STAGES-flop synchroniser per input, then one registered copy of sclk_s for edge detection.
  - Leading edge = sclk_s leaving cpol; trailing edge = sclk_s returning to cpol.
  - Sample edge = leading if cpha=0, trailing if cpha=1. Shift edge = the other edge.
- Timing requirement on the master:
  - sclk high and low time >= 4 clk cycles.
  - ss_n fall to first sclk edge >= 4 clk cycles.
  - Last sclk edge to ss_n rise >= 4 clk cycles.
  - The team master with dvsr>=3 satisfies this. dvsr=49 gives 1 MHz at 100 MHz (50 clk half period).
- States: IDLE (ss_n_s=1) and ACTIVE (ss_n_s=0).
- IDLE -> ACTIVE on the ss_n_s falling detect:
  - tx_sr <= din, bit_cnt <= 0, miso_oe <= 1, ready <= 0.
  - miso = tx_sr[DW-1] whenever miso_oe=1, else 0.
- On a sample edge in ACTIVE:
  - rx_sr <= {rx_sr[DW-2:0], mosi_s}; bit_cnt++.
  - When bit_cnt reaches DW: dout <= the completed byte, done=1 for exactly one clk, bit_cnt <= 0, tx_sr <= din (reload for the next frame).
- On a shift edge in ACTIVE:
  - tx_sr shifts left (LSB filled with 0) only if 1 <= bit_cnt <= DW-1. Otherwise the edge is ignored.
  - cpha=0: this suppresses the shift on the trailing edge after the last bit.
  - cpha=1: this suppresses the shift on the first leading edge of each frame.
- done latency: 1 clk after the registered sample-edge detect, i.e. SYNC_STAGES+2 clk after the sclk pin edge.
- Back-to-back frames without ss_n deassertion are supported. din is captured at the done cycle; the user must hold din valid there.
- ACTIVE -> IDLE on the ss_n_s rising detect:
  - miso_oe <= 0, ready <= 1.
  - If bit_cnt != 0: abort pulses 1 clk, partial rx data is discarded, dout is unchanged, no done.
  - bit_cnt <= 0.
- Simultaneous ss_n rise and a sample edge that would complete the byte: the sample is processed first (done=1, abort=0), then IDLE.
- sclk edges while IDLE are ignored; no counter or shift activity.
- rst low at any time (including mid-frame): immediately returns all state and outputs to reset values. After rst rises, a frame starts only on a fresh ss_n falling detect.

Test Plan:
- Mode 0 (cpol=0, cpha=0), team master dvsr=49, master din=A5, slave din=3C, one frame -> slave done pulses once, slave dout=A5, master dout=3C, ready low during the frame.
- Modes 1, 2, 3 repeated with master din=5A, slave din=C3 -> dout=5A and master receives C3 in each mode; miso_oe high only while ss_n low.
- Two back-to-back frames with ss_n held low (mode 3), masters 11/22 and slave din 81 then 42 (din changed at the first done) -> done twice, dout sequence 11 then 22, master receives 81 then 42.
- ss_n raised after 5 sclk sample edges (mode 0) -> abort pulses 1 clk, no done, dout keeps its previous value; the next full frame A5 -> dout=A5.
- rst asserted after 3 bits of a frame -> all outputs at reset values (dout=00, miso_oe=0, ready=1). A new frame after release receives FF correctly.
- sclk toggled 8 times with ss_n high -> no done, no abort, dout unchanged, miso=0.

Source files
------------

// File: rtl/spi_s.sv
// SPI slave endpoint: oversamples an asynchronous SPI bus in the clk domain and
// exchanges DW-bit frames, MSB first, in any cpol/cpha mode.
module spi_s #(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpol,
  input  logic          cpha,
  input  logic          sclk,
  input  logic          ss_n,
  input  logic          mosi,
  input  logic [DW-1:0] din,
  output logic          miso,
  output logic          miso_oe,
  output logic [DW-1:0] dout,
  output logic          done,
  output logic          ready,
  output logic          abort
);

  localparam int CW = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic          sclk_s, ss_s, mosi_s;
  logic          sclk_p0, ss_p0;
  logic          lead_p0, trail_p0;
  logic          sample_p1, shift_p1, ss_fall_p1, ss_rise_p1, mosi_p1;
  logic [CW-1:0] bit_cnt, cnt_after;
  logic [DW-1:0] rx_sr, rx_nxt, tx_sr;
  logic          last_bit;

  // Input synchronisers, reset to the idle bus state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Stage p0: delayed copies for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_p0 <= 1'b0;
      ss_p0   <= 1'b1;
    end else begin
      sclk_p0 <= sclk_s;
      ss_p0   <= ss_s;
    end
  end

  assign lead_p0  = (sclk_p0 == cpol) && (sclk_s != cpol);
  assign trail_p0 = (sclk_p0 != cpol) && (sclk_s == cpol);

  // Stage p1: registered events, mosi kept aligned with its sample strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_p1  <= 1'b0;
      shift_p1   <= 1'b0;
      ss_fall_p1 <= 1'b0;
      ss_rise_p1 <= 1'b0;
      mosi_p1    <= 1'b0;
    end else begin
      sample_p1  <= cpha ? trail_p0 : lead_p0;
      shift_p1   <= cpha ? lead_p0 : trail_p0;
      ss_fall_p1 <= ss_p0 & ~ss_s;
      ss_rise_p1 <= ~ss_p0 & ss_s;
      mosi_p1    <= mosi_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall_p1) state_nxt = ACTIVE;
      ACTIVE:  if (ss_rise_p1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A sample coinciding with deselect is applied before the abort decision
  always_comb begin
    rx_nxt    = {rx_sr[DW-2:0], mosi_p1};
    last_bit  = sample_p1 && (bit_cnt == LAST);
    cnt_after = bit_cnt;
    if (sample_p1) cnt_after = last_bit ? '0 : bit_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      dout    <= '0;
      done    <= 1'b0;
      abort   <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      if (state == IDLE) begin
        if (ss_fall_p1) begin
          tx_sr   <= din;
          bit_cnt <= '0;
        end
      end else begin
        if (sample_p1) begin
          rx_sr   <= rx_nxt;
          bit_cnt <= cnt_after;
          if (last_bit) begin
            dout <= rx_nxt;
            done <= 1'b1;
          end
        end else if (shift_p1 && bit_cnt != '0) begin
          tx_sr <= {tx_sr[DW-2:0], 1'b0};
        end
        // Reload one clk after completion so the user can update din on done
        if (done) tx_sr <= din;
        if (ss_rise_p1) begin
          bit_cnt <= '0;
          abort   <= (cnt_after != '0);
        end
      end
    end
  end

  assign miso_oe = (state == ACTIVE);
  assign ready   = (state == IDLE);
  assign miso    = miso_oe & tx_sr[DW-1];

endmodule

// File: tb/tb_spi_s.sv
// Bench for spi_s: behavioural SPI master drives all four modes; received
// bytes are scored against a queue of expected values as done pulses.
`timescale 1ns/1ps
module tb_spi_s;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, cpol, cpha, sclk, ss_n, mosi;
  logic [DW-1:0] din;
  logic          miso, miso_oe, done, ready, abort;
  logic [DW-1:0] dout;

  always #5 clk = ~clk;

  spi_s #(.SYNC_STAGES(2), .DW(DW)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk),
    .ss_n(ss_n), .mosi(mosi), .din(din), .miso(miso), .miso_oe(miso_oe),
    .dout(dout), .done(done), .ready(ready), .abort(abort)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pops the next expected byte
  always @(negedge clk) begin
    if (abort) abort_cnt++;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("spurious_done", 32'(done), 32'd0);
      else                   check("dout", 32'(dout), 32'(exp_q.pop_front()));
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sclk = p;
    wait_clk(6);
  endtask

  task automatic xfer_bits(input logic [7:0] mb, input int nb, input int half,
                           output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nb; i++) begin
      if (!cpha) begin
        mosi = mb[7-i];
        wait_clk(half);
        sclk = ~cpol;
        rx = {rx[6:0], miso};
        wait_clk(half);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mb[7-i];
        wait_clk(half);
        sclk = cpol;
        rx = {rx[6:0], miso};
        wait_clk(half);
      end
      if (i == 3) begin
        check("ready_busy", 32'(ready), 32'd0);
        check("oe_busy", 32'(miso_oe), 32'd1);
      end
    end
  endtask

  task automatic frame(input logic [7:0] mb, input logic [7:0] sd, input int half);
    logic [7:0] rx;
    int d0;
    din = sd;
    d0 = done_cnt;
    exp_q.push_back(mb);
    ss_n = 1'b0;
    wait_clk(half);
    xfer_bits(mb, 8, half, rx);
    wait_clk(half);
    ss_n = 1'b1;
    wait_clk(8);
    check("master_rx", 32'(rx), 32'(sd));
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("oe_idle", 32'(miso_oe), 32'd0);
    check("ready_idle", 32'(ready), 32'd1);
  endtask

  initial begin
    logic [7:0] rx1, rx2;
    logic [7:0] dout_hold;
    int d0, a0;
    rst = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    ss_n = 1'b1; mosi = 1'b0; din = '0;
    wait_clk(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_abort", 32'(abort), 32'd0);
    rst = 1'b1;
    wait_clk(4);

    // Mode 0 at a slow, master-like rate
    set_mode(1'b0, 1'b0);
    frame(8'hA5, 8'h3C, 50);

    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      frame(8'h5A, 8'hC3, 8);
    end

    // Back-to-back frames in mode 3, din updated when the first done appears
    set_mode(1'b1, 1'b1);
    din = 8'h81;
    d0 = done_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    fork
      begin
        for (int k = 0; k < 400 && !done; k++) @(negedge clk);
        din = 8'h42;
      end
    join_none
    ss_n = 1'b0;
    wait_clk(8);
    xfer_bits(8'h11, 8, 8, rx1);
    xfer_bits(8'h22, 8, 8, rx2);
    wait_clk(8);
    ss_n = 1'b1;
    wait_clk(8);
    check("b2b_rx1", 32'(rx1), 32'h81);
    check("b2b_rx2", 32'(rx2), 32'h42);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check("b2b_dout", 32'(dout), 32'h22);

    // Deselect after 5 bits
    set_mode(1'b0, 1'b0);
    dout_hold = dout;
    d0 = done_cnt;
    a0 = abort_cnt;
    din = 8'h00;
    ss_n = 1'b0;
    wait_clk(8);
    xfer_bits(8'hF0, 5, 8, rx1);
    wait_clk(8);
    ss_n = 1'b1;
    wait_clk(8);
    check("abort_cycles", 32'(abort_cnt - a0), 32'd1);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_dout_held", 32'(dout), 32'(dout_hold));
    frame(8'hA5, 8'h3C, 8);
    check("post_abort_dout", 32'(dout), 32'hA5);

    // Reset in the middle of a frame
    din = 8'h96;
    ss_n = 1'b0;
    wait_clk(8);
    xfer_bits(8'h0F, 3, 8, rx1);
    rst = 1'b0;
    #1;
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_oe", 32'(miso_oe), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_miso", 32'(miso), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_abort", 32'(abort), 32'd0);
    ss_n = 1'b1;
    sclk = cpol;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(6);
    frame(8'hFF, 8'h96, 8);
    check("post_rst_dout", 32'(dout), 32'hFF);

    // sclk activity while deselected
    dout_hold = dout;
    d0 = done_cnt;
    a0 = abort_cnt;
    for (int i = 0; i < 8; i++) begin
      sclk = ~sclk;
      mosi = ~mosi;
      wait_clk(6);
      check("idle_miso", 32'(miso), 32'd0);
    end
    wait_clk(6);
    check("idle_no_done", 32'(done_cnt - d0), 32'd0);
    check("idle_no_abort", 32'(abort_cnt - a0), 32'd0);
    check("idle_dout_held", 32'(dout), 32'(dout_hold));
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
